// File: rtl/dram_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dram_access_arbiter
// Brief    : Shares the DRAM sequencer between the 68000 CPU and a DMA master
//            and schedules periodic CAS-before-RAS refresh.
//            Optional macro ARB_CPU_FIXED_PRIO_EN: CPU always wins CPU/DMA ties.
// Revision : 1.0 - initial release
// ============================================================================
module dram_access_arbiter #(
  parameter int REFRESH_CYCLE_CNT = 150,
  parameter int CNT_W             = 12
) (
  input  logic CLK,
  input  logic RST,
  input  logic CS,
  input  logic AS,
  input  logic DMA_REQ,
  input  logic MEM_DONE,
  output logic MEM_START,
  output logic REF_START,
  output logic ADDR_SEL,
  output logic CPU_GNT,
  output logic DMA_GNT,
  output logic BUSY,
  output logic REF_OVERRUN
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CPU_ACC = 3'd1,
    S_DMA_ACC = 3'd2,
    S_REF     = 3'd3,
    S_CPU_REL = 3'd4
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] ref_cnt_q;
  logic [CNT_W-1:0] ref_cnt_d;
  logic             ref_pending_q;
  logic             ref_pending_d;
  logic             ref_overrun_q;
  logic             last_dma_q;
  logic             dma_done_q;
  logic             mem_start_q;
  logic             ref_start_q;
  logic             addr_sel_q;
  logic             cpu_gnt_q;
  logic             dma_gnt_q;
  logic             busy_q;

  logic             ref_wrap;
  logic             cpu_req;
  logic             cpu_wins_tie;
  logic             dma_done_seen;

  assign ref_wrap      = (ref_cnt_q == CNT_W'(REFRESH_CYCLE_CNT - 1));
  assign ref_cnt_d     = ref_wrap ? '0 : ref_cnt_q + 1'b1;
  assign cpu_req       = ~CS & ~AS;
  assign dma_done_seen = dma_done_q | MEM_DONE;

  // A wrap on the very edge that services the old request must survive.
  assign ref_pending_d = ref_wrap | (ref_pending_q & (state_q != S_IDLE));

`ifdef ARB_CPU_FIXED_PRIO_EN
  // History register is still tracked; fixed priority simply overrides it.
  assign cpu_wins_tie = last_dma_q | 1'b1;
`else
  assign cpu_wins_tie = last_dma_q;
`endif

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q       <= S_IDLE;
      ref_cnt_q     <= '0;
      ref_pending_q <= 1'b0;
      ref_overrun_q <= 1'b0;
      last_dma_q    <= 1'b1;
      dma_done_q    <= 1'b0;
      mem_start_q   <= 1'b0;
      ref_start_q   <= 1'b0;
      addr_sel_q    <= 1'b0;
      cpu_gnt_q     <= 1'b0;
      dma_gnt_q     <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      mem_start_q   <= 1'b0;
      ref_start_q   <= 1'b0;
      ref_cnt_q     <= ref_cnt_d;
      ref_pending_q <= ref_pending_d;
      if (ref_wrap && ref_pending_q) begin
        ref_overrun_q <= 1'b1;
      end

      case (state_q)
        S_IDLE: begin
          if (ref_pending_q) begin
            ref_start_q <= 1'b1;
            busy_q      <= 1'b1;
            state_q     <= S_REF;
          end else if (cpu_req && (!DMA_REQ || cpu_wins_tie)) begin
            mem_start_q <= 1'b1;
            addr_sel_q  <= 1'b0;
            cpu_gnt_q   <= 1'b1;
            busy_q      <= 1'b1;
            last_dma_q  <= 1'b0;
            state_q     <= S_CPU_ACC;
          end else if (DMA_REQ) begin
            mem_start_q <= 1'b1;
            addr_sel_q  <= 1'b1;
            dma_gnt_q   <= 1'b1;
            busy_q      <= 1'b1;
            last_dma_q  <= 1'b1;
            dma_done_q  <= 1'b0;
            state_q     <= S_DMA_ACC;
          end
        end

        S_CPU_ACC: begin
          if (MEM_DONE) begin
            if (AS) begin
              cpu_gnt_q <= 1'b0;
              busy_q    <= 1'b0;
              state_q   <= S_IDLE;
            end else begin
              state_q   <= S_CPU_REL;
            end
          end
        end

        // Grant is held until the 68000 ends its bus cycle, so the same
        // strobe cannot be seen as a fresh request.
        S_CPU_REL: begin
          if (AS) begin
            cpu_gnt_q <= 1'b0;
            busy_q    <= 1'b0;
            state_q   <= S_IDLE;
          end
        end

        S_DMA_ACC: begin
          if (dma_done_seen && !DMA_REQ) begin
            dma_gnt_q  <= 1'b0;
            addr_sel_q <= 1'b0;
            busy_q     <= 1'b0;
            dma_done_q <= 1'b0;
            state_q    <= S_IDLE;
          end else begin
            dma_done_q <= dma_done_seen;
          end
        end

        S_REF: begin
          if (MEM_DONE) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end

        default: begin
          addr_sel_q <= 1'b0;
          cpu_gnt_q  <= 1'b0;
          dma_gnt_q  <= 1'b0;
          busy_q     <= 1'b0;
          state_q    <= S_IDLE;
        end
      endcase
    end
  end

  assign MEM_START   = mem_start_q;
  assign REF_START   = ref_start_q;
  assign ADDR_SEL    = addr_sel_q;
  assign CPU_GNT     = cpu_gnt_q;
  assign DMA_GNT     = dma_gnt_q;
  assign BUSY        = busy_q;
  assign REF_OVERRUN = ref_overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_dram_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dram_access_arbiter
// Brief    : Self-checking bench for dram_access_arbiter (vector table plus
//            refresh / overrun / async-reset sequences).
// Revision : 1.0 - initial release
// ============================================================================
module tb_dram_access_arbiter;

  localparam int REF_CNT = 150;

  // Output vector order: {MEM_START, REF_START, ADDR_SEL, CPU_GNT, DMA_GNT, BUSY, REF_OVERRUN}
  localparam logic [6:0] E_IDLE     = 7'b0000000;
  localparam logic [6:0] E_CPU_GO   = 7'b1001010;
  localparam logic [6:0] E_CPU_HOLD = 7'b0001010;
  localparam logic [6:0] E_DMA_GO   = 7'b1010110;
  localparam logic [6:0] E_DMA_HOLD = 7'b0010110;
  localparam logic [6:0] E_REF_GO   = 7'b0100010;
  localparam logic [6:0] E_REF_HOLD = 7'b0000010;
  localparam logic [6:0] E_OVR      = 7'b0000001;

`ifdef ARB_CPU_FIXED_PRIO_EN
  localparam logic [6:0] E_TIE2 = E_CPU_GO;
`else
  localparam logic [6:0] E_TIE2 = E_DMA_GO;
`endif

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic CS = 1'b1;
  logic AS = 1'b1;
  logic DMA_REQ = 1'b0;
  logic MEM_DONE = 1'b0;
  logic MEM_START, REF_START, ADDR_SEL, CPU_GNT, DMA_GNT, BUSY, REF_OVERRUN;

  int checks = 0;
  int errors = 0;
  logic [6:0] exp_q[$];

  typedef struct {
    logic       cs;
    logic       as_n;
    logic       dma;
    logic       done;
    logic [6:0] exp;
  } vec_t;

  localparam int NV = 18;
  vec_t tbl[NV];

  always #5 CLK = ~CLK;

  dram_access_arbiter #(
    .REFRESH_CYCLE_CNT(REF_CNT),
    .CNT_W            (12)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .CS         (CS),
    .AS         (AS),
    .DMA_REQ    (DMA_REQ),
    .MEM_DONE   (MEM_DONE),
    .MEM_START  (MEM_START),
    .REF_START  (REF_START),
    .ADDR_SEL   (ADDR_SEL),
    .CPU_GNT    (CPU_GNT),
    .DMA_GNT    (DMA_GNT),
    .BUSY       (BUSY),
    .REF_OVERRUN(REF_OVERRUN)
  );

  function automatic logic [6:0] outs();
    return {MEM_START, REF_START, ADDR_SEL, CPU_GNT, DMA_GNT, BUSY, REF_OVERRUN};
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, queue the expected outputs, compare after the edge.
  task automatic drive_chk(input logic cs, input logic as_n, input logic dma,
                           input logic done, input logic [6:0] exp, input string name);
    CS       = cs;
    AS       = as_n;
    DMA_REQ  = dma;
    MEM_DONE = done;
    exp_q.push_back(exp);
    tick();
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      check(name, outs(), exp_q.pop_front());
    end
  endtask

  task automatic do_reset();
    CS = 1'b1; AS = 1'b1; DMA_REQ = 1'b0; MEM_DONE = 1'b0;
    RST = 1'b0;
    tick();
    tick();
    RST = 1'b1;
  endtask

  initial begin
    tbl[0]  = '{1'b0, 1'b0, 1'b1, 1'b0, E_CPU_GO};   // first tie: CPU
    tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b1, E_IDLE};
    tbl[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, E_TIE2};     // second tie
    tbl[3]  = '{1'b1, 1'b1, 1'b0, 1'b1, E_IDLE};
    tbl[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, E_CPU_GO};   // third tie
    tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b1, E_IDLE};
    tbl[6]  = '{1'b1, 1'b1, 1'b1, 1'b0, E_DMA_GO};
    tbl[7]  = '{1'b1, 1'b1, 1'b1, 1'b1, E_DMA_HOLD}; // done but request held
    tbl[8]  = '{1'b1, 1'b1, 1'b1, 1'b0, E_DMA_HOLD};
    tbl[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, E_IDLE};
    tbl[10] = '{1'b1, 1'b1, 1'b0, 1'b1, E_IDLE};     // stray done in idle
    tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b0, E_CPU_GO};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b0, E_CPU_HOLD};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b1, E_CPU_HOLD}; // done with AS low
    tbl[14] = '{1'b0, 1'b0, 1'b0, 1'b0, E_CPU_HOLD};
    tbl[15] = '{1'b1, 1'b1, 1'b0, 1'b0, E_IDLE};
    tbl[16] = '{1'b1, 1'b0, 1'b0, 1'b0, E_IDLE};     // AS without CS
    tbl[17] = '{1'b0, 1'b1, 1'b0, 1'b0, E_IDLE};     // CS without AS

    #1 RST = 1'b0;
    #1 check("reset_outputs", outs(), E_IDLE);
    tick();
    check("reset_held", outs(), E_IDLE);
    RST = 1'b1;

    for (int i = 0; i < NV; i++) begin
      drive_chk(tbl[i].cs, tbl[i].as_n, tbl[i].dma, tbl[i].done, tbl[i].exp,
                $sformatf("vec%0d", i));
    end

    // Idle refresh cadence: wrap on edge 150*k, REF_START one edge later.
    do_reset();
    for (int e = 1; e <= REF_CNT; e++) drive_chk(1, 1, 0, 0, E_IDLE, "idle_pre_ref1");
    drive_chk(1, 1, 0, 0, E_REF_GO,   "ref_start_1");
    drive_chk(1, 1, 0, 0, E_REF_HOLD, "ref_hold");
    drive_chk(1, 1, 0, 0, E_REF_HOLD, "ref_hold");
    drive_chk(1, 1, 0, 1, E_IDLE,     "ref_done");
    for (int e = REF_CNT + 5; e <= 2 * REF_CNT; e++) drive_chk(1, 1, 0, 0, E_IDLE, "idle_pre_ref2");
    drive_chk(1, 1, 0, 0, E_REF_GO,   "ref_start_2");
    drive_chk(1, 1, 0, 1, E_IDLE,     "ref2_done");

    // Threshold hit during a DMA access with the CPU waiting.
    do_reset();
    for (int e = 1; e <= REF_CNT - 10; e++) drive_chk(1, 1, 0, 0, E_IDLE, "idle_pre_dma");
    drive_chk(1, 1, 1, 0, E_DMA_GO, "dma_grant");
    for (int e = REF_CNT - 8; e <= REF_CNT; e++) drive_chk(0, 0, 1, 0, E_DMA_HOLD, "dma_hold_cpu_wait");
    drive_chk(0, 0, 1, 1, E_DMA_HOLD, "dma_done_req_held");
    drive_chk(0, 0, 0, 0, E_IDLE,     "dma_release");
    drive_chk(0, 0, 0, 0, E_REF_GO,   "ref_before_cpu");
    drive_chk(0, 0, 0, 0, E_REF_HOLD, "ref_hold_cpu_wait");
    drive_chk(0, 0, 0, 1, E_IDLE,     "ref_done_cpu_wait");
    drive_chk(0, 0, 0, 0, E_CPU_GO,   "cpu_after_ref");
    drive_chk(1, 1, 0, 1, E_IDLE,     "cpu_done");

    // DMA held open across two refresh intervals.
    do_reset();
    drive_chk(1, 1, 1, 0, E_DMA_GO, "ovr_dma_grant");
    for (int e = 2; e < 2 * REF_CNT; e++) drive_chk(1, 1, 1, 0, E_DMA_HOLD, "ovr_not_yet");
    drive_chk(1, 1, 1, 0, E_DMA_HOLD | E_OVR, "overrun_set");
    for (int e = 1; e <= 5; e++) drive_chk(1, 1, 1, 0, E_DMA_HOLD | E_OVR, "overrun_sticky");
    drive_chk(1, 1, 1, 1, E_DMA_HOLD | E_OVR, "ovr_dma_done");
    drive_chk(1, 1, 0, 0, E_IDLE | E_OVR,     "ovr_idle");
    drive_chk(1, 1, 0, 0, E_REF_GO | E_OVR,   "ovr_ref_start");

    // Asynchronous reset in the middle of a cycle.
    #2 RST = 1'b0;
    #1 check("async_reset_immediate", outs(), E_IDLE);
    tick();
    check("async_reset_held", outs(), E_IDLE);
    RST = 1'b1;
    drive_chk(1, 1, 0, 0, E_IDLE, "post_reset_idle");
    drive_chk(1, 1, 1, 0, E_DMA_GO, "post_reset_dma");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
